// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Define REGFILE_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins, no pointer register).
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [(2**ADDR_W)-1:0]    busy,
  output logic [15:0]               drop_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic                   slot_valid_r;
  logic [ADDR_W-1:0]      wr_addr_r;
  logic [DATA_W-1:0]      wr_data_r;
  logic [15:0]            drop_cnt_r;

  logic                   wr_en_s;
  logic                   can_accept_s;
  logic                   grant_any_s;
  logic [IDX_W-1:0]       grant_idx_s;
  logic [ADDR_W-1:0]      sel_addr_s;
  logic [DATA_W-1:0]      sel_data_s;
  logic                   hs_s;
  logic [NUM_REQ-1:0]     req_ready_s;
  logic [(2**ADDR_W)-1:0] busy_s;
  int                     dist_s;
  int                     best_s;

`ifndef REGFILE_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]       last_r;
`endif

  assign wr_en_s      = slot_valid_r & ~wr_stall;
  assign can_accept_s = ~slot_valid_r | wr_en_s;
  assign hs_s         = grant_any_s & can_accept_s;

  // Winner search: each valid requester gets a priority distance, the smallest distance wins
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    sel_addr_s  = '0;
    sel_data_s  = '0;
    best_s      = NUM_REQ;
    dist_s      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      dist_s = i;
`else
      // distance from the slot just after the last granted index, wrapping
      dist_s = (i > int'(last_r)) ? (i - int'(last_r) - 1)
                                  : (i - int'(last_r) - 1 + NUM_REQ);
`endif
      if (req_valid[i] && (dist_s < best_s)) begin
        best_s      = dist_s;
        grant_any_s = 1'b1;
        grant_idx_s = IDX_W'(i);
        sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data_s  = req_data[i*DATA_W +: DATA_W];
      end else begin
        best_s      = best_s;
      end
    end
  end

  // One-hot ready toward the winner, gated by slot availability
  always_comb begin
    req_ready_s = '0;
    if (grant_any_s) begin
      req_ready_s[grant_idx_s] = can_accept_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Write slot, drop counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
      drop_cnt_r   <= 16'h0000;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
      last_r       <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      if (hs_s) begin
`ifndef REGFILE_ARB_FIXED_PRIO_EN
        last_r <= grant_idx_s;
`endif
        if (sel_addr_s != '0) begin
          slot_valid_r <= 1'b1;
          wr_addr_r    <= sel_addr_s;
          wr_data_r    <= sel_data_s;
        end else begin
          // register 0 is hardwired: consume the request, count it, never write it
          if (drop_cnt_r != 16'hFFFF) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
          end else begin
            drop_cnt_r <= drop_cnt_r;
          end
          if (wr_en_s) begin
            slot_valid_r <= 1'b0;
          end else begin
            slot_valid_r <= slot_valid_r;
          end
        end
      end else if (wr_en_s) begin
        slot_valid_r <= 1'b0;
      end else begin
        slot_valid_r <= slot_valid_r;
      end
    end
  end

  // Busy bitmap decoded from the slot registers only
  always_comb begin
    busy_s = '0;
    if (slot_valid_r) begin
      busy_s[wr_addr_r] = 1'b1;
    end else begin
      busy_s = '0;
    end
  end

  assign req_ready = req_ready_s;
  assign wr_en     = wr_en_s;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign busy      = busy_s;
  assign drop_cnt  = drop_cnt_r;

  regfile_write_arbiter_chk #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready_s),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en_s),
    .wr_addr   (wr_addr_r),
    .busy      (busy_s)
  );

endmodule

// Protocol checker: grant shape, stall hold-off and busy bitmap consistency.
module regfile_write_arbiter_chk #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5
) (
  input logic                   clk,
  input logic                   rst,
  input logic [NUM_REQ-1:0]     req_valid,
  input logic [NUM_REQ-1:0]     req_ready,
  input logic                   wr_stall,
  input logic                   wr_en,
  input logic [ADDR_W-1:0]      wr_addr,
  input logic [(2**ADDR_W)-1:0] busy
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (rst)
    ((req_ready & ~req_valid) == '0));

  a_stall_blocks: assert property (@(posedge clk) disable iff (rst)
    (wr_stall && (busy != '0)) |-> ((req_ready == '0) && !wr_en));

  a_busy_single: assert property (@(posedge clk) disable iff (rst)
    $onehot0(busy));

  a_write_is_busy: assert property (@(posedge clk) disable iff (rst)
    wr_en |-> busy[wr_addr]);

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (a3/we3/wd3) among NUM_REQ writeback sources, e.g. ALU result, load result and debug/host poke.
- Round-robin arbitration with valid/ready handshake per requester.
- One-entry registered write slot drives the register file; the slot can be held off by a stall input.
- Exports a busy bitmap of the register currently pending write, for hazard checks.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, write data width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; handshake = valid & ready
wr_stall  input  1  holds the write slot; no register file write while high
wr_en  output  1  to register file we3
wr_addr  output  ADDR_W  to register file a3
wr_data  output  DATA_W  to register file wd3
busy  output  2**ADDR_W  bit k high while a write to register k sits in the slot
drop_cnt  output  16  count of accepted writes to register 0 (discarded)

Behaviour:
- Reset values, synchronous on rst, which overrides everything including a mid-stall slot:
  - slot_valid=0, wr_addr=0, wr_data=0, busy=0, drop_cnt=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset.
- wr_en = slot_valid & ~wr_stall (combinational). The slot empties on the cycle wr_en=1.
- can_accept = ~slot_valid | wr_en (combinational).
- Arbitration is combinational each cycle:
  - Search req_valid starting at index (last+1) mod NUM_REQ, wrapping around. The first valid index is the winner.
  - req_ready[winner]=can_accept. All other ready bits are 0.
  - No valid request gives req_ready=0.
  - req_ready depends on req_valid but requesters must not make valid depend on ready.
- On handshake of winner g:
  - last<=g. The pointer updates only on a handshake, never on a bare request.
  - If req_addr[g]!=0: slot_valid<=1, wr_addr<=req_addr[g], wr_data<=req_data[g].
  - If req_addr[g]==0: request is consumed (ready high), slot not loaded, drop_cnt<=drop_cnt+1 (saturating at 16'hFFFF). If the slot empties the same cycle, slot_valid<=0.
- Without a handshake: if wr_en then slot_valid<=0, else the slot holds. wr_addr/wr_data hold their last value while the slot is empty.
- Latency: a request accepted in cycle N gives wr_en in cycle N+1 when wr_stall=0. Sustained throughput is one write per cycle.
- Simultaneous drain and accept in the same cycle: the old entry writes (wr_en=1) and the new entry loads. There is no bubble.
- wr_stall=1 with slot full: can_accept=0, all req_ready=0, and slot contents are stable.
- busy = slot_valid ? (1<<wr_addr) : 0. It is registered-derived, with no combinational path from req_*.
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,2,0,...
- Requester contract: while valid, hold addr/data stable until the handshake. The arbiter does not check this.

Optional Feature:
REGFILE_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest valid index wins. The pointer register is removed and last is unused. All other behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset then req_valid=3'b001, addr0=5'd2, data0=32'hDEAD_BEEF -> req_ready=3'b001 in cycle N; wr_en=1, wr_addr=2, wr_data=DEADBEEF in N+1; busy=32'h4 in N+1; slot empty in N+2.
- req_valid=3'b111 held 6 cycles, wr_stall=0, distinct addrs 1/2/3 -> grant sequence 0,1,2,0,1,2 and wr_en high every cycle from N+1. With REGFILE_ARB_FIXED_PRIO_EN the grant is 0 every cycle.
- Fill slot (addr 5), then wr_stall=1 for 3 cycles with req_valid=3'b010 -> req_ready=0, wr_en=0, busy=32'h20 stable. Stall drops -> wr_en=1 addr 5 and req_ready[1]=1 in the same cycle; requester 1's write follows next cycle.
- Requester 2 writes addr 0, data 32'h1234 -> req_ready[2]=1, wr_en never asserts, drop_cnt 0->1, busy stays 0.
- rst asserted while slot holds addr 7 under wr_stall=1 -> next cycle wr_en=0, busy=0, drop_cnt=0. First post-reset grant with req_valid=3'b110 goes to requester 1.
- Back-to-back requester 0 only, addrs 1..4 over 4 cycles -> four consecutive wr_en pulses with matching addr/data and no idle cycles.
